// File: rtl/prim_req_queue_pkg.sv
// Shared types and helpers for the prim_req_queue block.
package prim_req_queue_pkg;

    typedef enum logic [1:0] {
        ErrNone,
        ErrGntNoReq,
        ErrMultiGnt
    } req_queue_err_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prim_req_queue_port.sv
// Single-port circular FIFO feeding one arbiter input; head held stable until popped.
// Optional empty-queue fall-through when PRIM_REQ_QUEUE_BYPASS_EN is defined.
module prim_req_queue_port
    import prim_req_queue_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int Depth = 2,
    localparam int CntW  = cnt_width(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [DW-1:0]   in_data_i,
    input  logic            pop_en_i,
    output logic            req_o,
    output logic [DW-1:0]   data_o,
    output logic [CntW-1:0] cnt_o
);

    localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] Full    = CntW'(Depth);

    logic [DW-1:0]   mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stored, wr_en, rd_en;
    logic [DW-1:0]   head;

    assign stored     = (cnt_q != '0);
    assign in_ready_o = (cnt_q != Full);
    assign head       = mem_q[rptr_q];
    assign cnt_o      = cnt_q;

`ifdef PRIM_REQ_QUEUE_BYPASS_EN
    logic byp, push, pop;
    always_comb begin
        byp    = ~stored & in_valid_i;
        req_o  = stored | byp;
        data_o = stored ? head : (byp ? in_data_i : '0);
        push   = in_valid_i & in_ready_o;
        pop    = pop_en_i & req_o;
        // A bypassed entry granted in its arrival cycle never touches storage.
        wr_en  = push & ~(byp & pop);
        rd_en  = pop & stored;
    end
`else
    always_comb begin
        req_o  = stored;
        data_o = stored ? head : '0;
        wr_en  = in_valid_i & in_ready_o;
        rd_en  = pop_en_i & stored;
    end
`endif

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            if (rd_en) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i && !rst_i) mem_q[wptr_q] <= in_data_i;
    end

endmodule

// File: rtl/prim_req_queue.sv
// N-port request queue in front of a round-robin arbiter, plus sticky grant-protocol checker.
// Fall-through on empty ports is enabled by defining PRIM_REQ_QUEUE_BYPASS_EN.
module prim_req_queue
    import prim_req_queue_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int DW    = 32,
    parameter  int Depth = 2,
    localparam int CntW  = cnt_width(Depth)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [N-1:0]              in_valid_i,
    output logic [N-1:0]              in_ready_o,
    input  logic [N-1:0][DW-1:0]      in_data_i,
    output logic [N-1:0]              req_o,
    output logic [N-1:0][DW-1:0]      data_o,
    input  logic [N-1:0]              gnt_i,
    output logic [N-1:0][CntW-1:0]    cnt_o,
    output logic                      err_o
);

    req_queue_err_e err_cls;
    logic           err_q, err_d;
    logic [N-1:0]   pop_en;

    // A multi-hot grant is discarded entirely; a grant to an idle port pops nothing anyway.
    always_comb begin
        err_cls = ErrNone;
        if ($countones(gnt_i) > 1)   err_cls = ErrMultiGnt;
        else if (|(gnt_i & ~req_o))  err_cls = ErrGntNoReq;
        err_d  = err_q | (err_cls != ErrNone);
        pop_en = (err_cls == ErrMultiGnt) ? '0 : gnt_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;

    for (genvar i = 0; i < N; i++) begin : g_port
        prim_req_queue_port #(
            .DW    (DW),
            .Depth (Depth)
        ) u_port (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .in_valid_i (in_valid_i[i]),
            .in_ready_o (in_ready_o[i]),
            .in_data_i  (in_data_i[i]),
            .pop_en_i   (pop_en[i]),
            .req_o      (req_o[i]),
            .data_o     (data_o[i]),
            .cnt_o      (cnt_o[i])
        );
    end

endmodule

// File: tb/tb_prim_req_queue.sv
// Scoreboard bench: stimulus queues expected pops, monitors compare on each granted request.
module tb_prim_req_queue;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, flush0, flush1;
    logic [N-1:0]        iv0, ir0, req0, gnt0, iv1, ir1, req1, gnt1;
    logic [N-1:0][DW-1:0] id0, do0, id1, do1;
    logic [N-1:0][1:0]   cnt0, cnt1;
    logic                err0, err1;

    prim_req_queue #(.N(N), .DW(DW), .Depth(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush0), .in_valid_i(iv0), .in_ready_o(ir0),
        .in_data_i(id0), .req_o(req0), .data_o(do0), .gnt_i(gnt0), .cnt_o(cnt0), .err_o(err0));

    prim_req_queue #(.N(N), .DW(DW), .Depth(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush1), .in_valid_i(iv1), .in_ready_o(ir1),
        .in_data_i(id1), .req_o(req1), .data_o(do1), .gnt_i(gnt1), .cnt_o(cnt1), .err_o(err1));

    int n_chk = 0, n_fail = 0, n_pop1 = 0;
    logic [7:0] exp0 [N][$];
    logic [7:0] exp1 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush0 && $countones(gnt0) == 1) begin
            for (int p = 0; p < N; p++) begin
                if (gnt0[p] && req0[p]) begin
                    if (exp0[p].size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL pop0_unexpected port %0d: got %0h required none", p, do0[p]);
                    end else begin
                        chk($sformatf("pop0_p%0d", p), 32'(do0[p]), 32'(exp0[p].pop_front()));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && gnt1[0] && req1[0]) begin
            n_pop1++;
            if (exp1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL pop1_unexpected: got %0h required none", do1[0]);
            end else begin
                chk("pop1_order", 32'(do1[0]), 32'(exp1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc, mcnt, maxc;
        logic wpush, wpop;
        rst = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
        iv0 = '0; id0 = '0; gnt0 = '0; iv1 = '0; id1 = '0; gnt1 = '0;
        tick(); tick();
        chk("rst_req", 32'(req0), 0);
        chk("rst_ready", 32'(ir0), 32'hf);
        chk("rst_err", 32'(err0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_data", do0, 0);
        rst = 1'b0;

        // fill port 2 to capacity, then hold with an extra push attempt while full
        iv0 = 4'b0100; id0[2] = 8'hA1; exp0[2].push_back(8'hA1); tick();
        id0[2] = 8'hA2; exp0[2].push_back(8'hA2); tick();
        id0[2] = 8'hA3;
        chk("full_cnt", 32'(cnt0[2]), 2);
        chk("full_ready", 32'(ir0[2]), 0);
        chk("full_req", 32'(req0[2]), 1);
        chk("full_head", 32'(do0[2]), 32'hA1);
        for (int i = 0; i < 10; i++) begin
            tick();
            iv0 = '0;
            chk("hold_req", 32'(req0[2]), 1);
            chk("hold_data", 32'(do0[2]), 32'hA1);
        end
        chk("hold_cnt", 32'(cnt0[2]), 2);

        // drain port 2
        gnt0 = 4'b0100; tick();
        chk("drain_mid_head", 32'(do0[2]), 32'hA2);
        tick(); gnt0 = '0;
        chk("drain_req", 32'(req0[2]), 0);
        chk("drain_cnt", 32'(cnt0[2]), 0);
        chk("drain_data", 32'(do0[2]), 0);

        // simultaneous push and pop with cnt=1
        iv0 = 4'b0010; id0[1] = 8'hB1; exp0[1].push_back(8'hB1); tick();
        chk("sim_cnt1", 32'(cnt0[1]), 1);
        id0[1] = 8'hB2; exp0[1].push_back(8'hB2); gnt0 = 4'b0010; tick();
        iv0 = '0; gnt0 = '0;
        chk("sim_cnt_hold", 32'(cnt0[1]), 1);
        chk("sim_new_head", 32'(do0[1]), 32'hB2);
        gnt0 = 4'b0010; tick(); gnt0 = '0;
        chk("sim_empty", 32'(req0[1]), 0);

        // full queue refuses input even while being popped
        iv0 = 4'b0001; id0[0] = 8'hC1; exp0[0].push_back(8'hC1); tick();
        id0[0] = 8'hC2; exp0[0].push_back(8'hC2); tick();
        id0[0] = 8'hC3; gnt0 = 4'b0001;
        chk("fullpop_ready", 32'(ir0[0]), 0);
        tick(); iv0 = '0;
        chk("fullpop_cnt", 32'(cnt0[0]), 1);
        chk("fullpop_head", 32'(do0[0]), 32'hC2);
        tick(); gnt0 = '0;
        chk("fullpop_empty", 32'(cnt0[0]), 0);

        // flush drops the same-cycle push
        iv0 = 4'b1000; id0[3] = 8'hD1; tick();
        flush0 = 1'b1; id0[3] = 8'hD2; tick();
        flush0 = 1'b0; iv0 = '0;
        chk("flush_cnt", 32'(cnt0), 0);
        chk("flush_req", 32'(req0), 0);
        tick();
        chk("flush_dropped", 32'(req0[3]), 0);

        // grant without request
        gnt0 = 4'b0001; tick(); gnt0 = '0;
        chk("err_gnt_noreq", 32'(err0), 1);
        flush0 = 1'b1; tick(); flush0 = 1'b0;
        chk("err_sticky_flush", 32'(err0), 1);

        // multi-hot grant: flagged and ignored
        rst = 1'b1; tick(); rst = 1'b0;
        chk("err_rst_clear", 32'(err0), 0);
        iv0 = 4'b0011; id0[0] = 8'hE0; id0[1] = 8'hE1;
        exp0[0].push_back(8'hE0); exp0[1].push_back(8'hE1); tick();
        iv0 = '0; gnt0 = 4'b0011; tick(); gnt0 = '0;
        chk("err_multi", 32'(err0), 1);
        chk("multi_cnt0", 32'(cnt0[0]), 1);
        chk("multi_cnt1", 32'(cnt0[1]), 1);
        chk("multi_head0", 32'(do0[0]), 32'hE0);
        gnt0 = 4'b0001; tick();
        gnt0 = 4'b0010; tick(); gnt0 = '0;
        chk("multi_drained", 32'(req0), 0);

`ifdef PRIM_REQ_QUEUE_BYPASS_EN
        iv0 = 4'b0010; id0[1] = 8'h55; gnt0 = 4'b0010; exp0[1].push_back(8'h55);
        #1;
        chk("byp_req", 32'(req0[1]), 1);
        chk("byp_data", 32'(do0[1]), 32'h55);
        tick(); iv0 = '0; gnt0 = '0;
        chk("byp_cnt", 32'(cnt0[1]), 0);
        chk("byp_req_after", 32'(req0[1]), 0);
`endif

        // wrap-around at Depth=3: push 0x10..0x16, grant on odd cycles
        idx = 0; cyc = 0; mcnt = 0; maxc = 0;
        while ((idx < 7 || req1[0]) && cyc < 60) begin
            iv1[0] = (idx < 7);
            id1[0] = 8'(8'h10 + idx);
            gnt1[0] = cyc[0];
            wpush = (idx < 7) && ir1[0];
            wpop  = gnt1[0] && (mcnt != 0);
`ifdef PRIM_REQ_QUEUE_BYPASS_EN
            if (mcnt == 0 && wpush && gnt1[0]) wpush = 1'b0;
`endif
            if ((idx < 7) && ir1[0]) begin
                exp1.push_back(8'(8'h10 + idx));
                idx++;
            end
            mcnt = mcnt + int'(wpush) - int'(wpop);
            tick();
            chk("wrap_cnt", 32'(cnt1[0]), mcnt);
            if (int'(cnt1[0]) > maxc) maxc = int'(cnt1[0]);
            cyc++;
        end
        iv1 = '0; gnt1 = '0;
        chk("wrap_timeout", 32'(cyc < 60), 1);
        chk("wrap_pops", n_pop1, 7);
        chk("wrap_max", maxc, 3);

        tick();
        for (int p = 0; p < N; p++) chk($sformatf("sb0_left_p%0d", p), exp0[p].size(), 0);
        chk("sb1_left", exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
